// File: rtl/sweep_pkg.sv
// sweep_pkg -- shared types and tables for the sweep monitor.
//   state_t  : FSM state encoding. The low two bits are the externally
//              visible state code. INIT and LOCK both read 2'b00, because
//              INIT only lasts for the first sample after reset.
//   step_t   : classification of the step between consecutive samples.
//   SEG_GLYPH: active-high {g,f,e,d,c,b,a} glyphs for hex digits 0-F.
//   classify : maps delta = cnt - prev (mod 16) onto a step class.
package sweep_pkg;

   typedef enum logic [2:0] {
      ST_LOCK  = 3'b000,
      ST_UP    = 3'b001,
      ST_DOWN  = 3'b010,
      ST_FAULT = 3'b011,
      ST_INIT  = 3'b100
   } state_t;

   typedef enum logic [1:0] {
      STEP_HOLD,
      STEP_UP,
      STEP_DN,
      STEP_JUMP
   } step_t;

   localparam logic [6:0] SEG_GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic step_t classify(input logic [3:0] delta);
      case (delta)
         4'd0:    return STEP_HOLD;
         4'd1:    return STEP_UP;
         4'd15:   return STEP_DN;
         default: return STEP_JUMP;
      endcase
   endfunction

endpackage

// File: rtl/sweep_monitor_hex7seg.sv
// hex7seg -- combinational 4-bit to 7-segment decoder.
//   i_hex : hex digit to display
//   o_seg : active-high segments {g,f,e,d,c,b,a}
module hex7seg
   import sweep_pkg::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   assign o_seg = SEG_GLYPH[i_hex];

endmodule

// File: rtl/sweep_monitor.sv
// sweep_monitor -- watches an up/down sweep counter and reports its behaviour.
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous active-high reset
//   cnt_in     : counter value, sampled every clock
//   clr_stats  : synchronous clear of cycles and err_count
//   dir        : inferred direction (0 up, 1 down), held while in FAULT
//   state      : low two bits of the FSM state (INIT and LOCK both read 0)
//   cycles     : completed 0->15->0 sweeps, wrapping
//   err_count  : saturating count of step_err pulses
//   step_err   : one-cycle pulse on an illegal step
//   at_top     : one-cycle pulse on a legal 15->14 turnaround
//   at_bottom  : one-cycle pulse on a legal 0->1 turnaround (a sweep completes)
//   seg        : registered hex glyph of cnt_in
module sweep_monitor
   import sweep_pkg::*;
#(
   parameter int CYCLE_W = 8,
   parameter int ERR_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         cnt_in,
   input  logic               clr_stats,
   output logic               dir,
   output logic [1:0]         state,
   output logic [CYCLE_W-1:0] cycles,
   output logic [ERR_W-1:0]   err_count,
   output logic               step_err,
   output logic               at_top,
   output logic               at_bottom,
   output logic [6:0]         seg
);

   state_t             r_state;
   logic [3:0]         r_prev;
   logic               r_dir;
   logic [CYCLE_W-1:0] r_cycles;
   logic [ERR_W-1:0]   r_err_count;
   logic               r_step_err;
   logic               r_at_top;
   logic               r_at_bottom;
   logic [6:0]         r_seg;

   logic [3:0]         w_delta;
   step_t              w_step;
   state_t             w_next_state;
   logic               w_next_dir;
   logic               w_step_err;
   logic               w_at_top;
   logic               w_at_bottom;
   logic [6:0]         w_seg;

   hex7seg u_hex7seg (
      .i_hex (cnt_in),
      .o_seg (w_seg)
   );

   assign w_delta = cnt_in - r_prev;
   assign w_step  = classify(w_delta);

   // NOTE: every always_comb output gets a default before the case, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_step_err   = 1'b0;
      w_at_top     = 1'b0;
      w_at_bottom  = 1'b0;
      case (r_state)
         ST_INIT: w_next_state = ST_LOCK;
         ST_LOCK: begin
            case (w_step)
               STEP_UP:   w_next_state = ST_UP;
               STEP_DN:   w_next_state = ST_DOWN;
               STEP_JUMP: w_step_err   = 1'b1;
               default:   ;
            endcase
         end
         ST_UP: begin
            // A step up from 15 is the 15->0 wrap, which is not a legal sweep.
            if (w_step == STEP_HOLD || (w_step == STEP_UP && r_prev != 4'hF)) begin
               w_next_state = ST_UP;
            end else if (w_step == STEP_DN && r_prev == 4'hF) begin
               w_next_state = ST_DOWN;
               w_at_top     = 1'b1;
            end else begin
               w_next_state = ST_FAULT;
               w_step_err   = 1'b1;
            end
         end
         ST_DOWN: begin
            if (w_step == STEP_HOLD || (w_step == STEP_DN && r_prev != 4'h0)) begin
               w_next_state = ST_DOWN;
            end else if (w_step == STEP_UP && r_prev == 4'h0) begin
               w_next_state = ST_UP;
               w_at_bottom  = 1'b1;
            end else begin
               w_next_state = ST_FAULT;
               w_step_err   = 1'b1;
            end
         end
         ST_FAULT: begin
            // Recovery needs the counter back at zero; that sample is not an error.
            if (cnt_in == 4'h0) begin
               w_next_state = ST_LOCK;
            end else if (w_step != STEP_HOLD) begin
               w_step_err = 1'b1;
            end
         end
         default: w_next_state = ST_INIT;
      endcase
   end

   // dir follows the state being entered; FAULT keeps whatever it had.
   always_comb begin
      w_next_dir = 1'b0;
      case (w_next_state)
         ST_DOWN:  w_next_dir = 1'b1;
         ST_FAULT: w_next_dir = r_dir;
         default:  w_next_dir = 1'b0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_INIT;
         r_prev      <= 4'h0;
         r_dir       <= 1'b0;
         r_cycles    <= '0;
         r_err_count <= '0;
         r_step_err  <= 1'b0;
         r_at_top    <= 1'b0;
         r_at_bottom <= 1'b0;
         r_seg       <= SEG_GLYPH[0];
      end else begin
         r_state     <= w_next_state;
         r_prev      <= cnt_in;
         r_dir       <= w_next_dir;
         r_step_err  <= w_step_err;
         r_at_top    <= w_at_top;
         r_at_bottom <= w_at_bottom;
         r_seg       <= w_seg;
         if (clr_stats) begin
            r_cycles    <= '0;
            r_err_count <= '0;
         end else begin
            if (w_at_bottom) r_cycles <= r_cycles + CYCLE_W'(1);
            if (w_step_err && r_err_count != '1) r_err_count <= r_err_count + ERR_W'(1);
         end
      end
   end

   assign state     = r_state[1:0];
   assign dir       = r_dir;
   assign cycles    = r_cycles;
   assign err_count = r_err_count;
   assign step_err  = r_step_err;
   assign at_top    = r_at_top;
   assign at_bottom = r_at_bottom;
   assign seg       = r_seg;

endmodule

// File: tb/tb_sweep_monitor.sv
// tb_sweep_monitor -- directed bench for sweep_monitor (CYCLE_W=4, ERR_W=4).
module tb_sweep_monitor;

   localparam logic [1:0] S_LOCK  = 2'd0;
   localparam logic [1:0] S_UP    = 2'd1;
   localparam logic [1:0] S_DOWN  = 2'd2;
   localparam logic [1:0] S_FAULT = 2'd3;

   logic [6:0] glyph [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic       clk;
   logic       rst;
   logic [3:0] cnt_in;
   logic       clr_stats;
   logic       dir;
   logic [1:0] state;
   logic [3:0] cycles;
   logic [3:0] err_count;
   logic       step_err;
   logic       at_top;
   logic       at_bottom;
   logic [6:0] seg;

   int n_vec;
   int n_miscmp;

   sweep_monitor #(.CYCLE_W(4), .ERR_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .cnt_in    (cnt_in),
      .clr_stats (clr_stats),
      .dir       (dir),
      .state     (state),
      .cycles    (cycles),
      .err_count (err_count),
      .step_err  (step_err),
      .at_top    (at_top),
      .at_bottom (at_bottom),
      .seg       (seg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one sample, let it be taken at the next edge, settle 1 time unit.
   task automatic drive(input logic [3:0] v);
      cnt_in = v;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      cnt_in    = 4'h0;
      clr_stats = 1'b0;
      rst       = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; cnt_in = 4'h5; clr_stats = 1'b0;
      #3;
      n_vec++; if (state !== S_LOCK) begin n_miscmp++; $display("FAIL rst_state got=%0d exp=%0d", state, S_LOCK); end
      n_vec++; if (dir !== 1'b0) begin n_miscmp++; $display("FAIL rst_dir got=%0b exp=0", dir); end
      n_vec++; if (cycles !== 4'd0) begin n_miscmp++; $display("FAIL rst_cycles got=%0d exp=0", cycles); end
      n_vec++; if (err_count !== 4'd0) begin n_miscmp++; $display("FAIL rst_err got=%0d exp=0", err_count); end
      n_vec++; if ({step_err, at_top, at_bottom} !== 3'b000) begin n_miscmp++; $display("FAIL rst_pulses got=%b exp=000", {step_err, at_top, at_bottom}); end
      n_vec++; if (seg !== 7'h3F) begin n_miscmp++; $display("FAIL rst_seg got=%h exp=3f", seg); end
   endtask

   task automatic test_full_sweep();
      int n_top;
      int n_bot;
      int n_err;
      n_top = 0; n_bot = 0; n_err = 0;
      apply_reset();
      for (int v = 0; v <= 15; v++) begin
         drive(4'(v));
         n_top += int'(at_top); n_bot += int'(at_bottom); n_err += int'(step_err);
         n_vec++; if (seg !== glyph[v]) begin n_miscmp++; $display("FAIL sweep_seg_up v=%0d got=%h exp=%h", v, seg, glyph[v]); end
         if (v >= 1) begin
            n_vec++; if (state !== S_UP) begin n_miscmp++; $display("FAIL sweep_state_up v=%0d got=%0d exp=%0d", v, state, S_UP); end
         end
      end
      drive(4'd14);
      n_vec++; if (at_top !== 1'b1) begin n_miscmp++; $display("FAIL sweep_at_top got=%0b exp=1", at_top); end
      n_vec++; if (state !== S_DOWN || dir !== 1'b1) begin n_miscmp++; $display("FAIL sweep_turn_down state=%0d dir=%0b exp=2,1", state, dir); end
      n_top += int'(at_top); n_err += int'(step_err);
      for (int v = 13; v >= 0; v--) begin
         drive(4'(v));
         n_top += int'(at_top); n_bot += int'(at_bottom); n_err += int'(step_err);
         n_vec++; if (seg !== glyph[v] || state !== S_DOWN) begin n_miscmp++; $display("FAIL sweep_down v=%0d seg=%h state=%0d exp=%h,2", v, seg, state, glyph[v]); end
      end
      drive(4'd1);
      n_top += int'(at_top); n_err += int'(step_err); n_bot += int'(at_bottom);
      n_vec++; if (at_bottom !== 1'b1) begin n_miscmp++; $display("FAIL sweep_at_bottom got=%0b exp=1", at_bottom); end
      n_vec++; if (cycles !== 4'd1) begin n_miscmp++; $display("FAIL sweep_cycles got=%0d exp=1", cycles); end
      n_vec++; if (state !== S_UP || dir !== 1'b0) begin n_miscmp++; $display("FAIL sweep_turn_up state=%0d dir=%0b exp=1,0", state, dir); end
      drive(4'd2);
      n_vec++; if (at_bottom !== 1'b0) begin n_miscmp++; $display("FAIL sweep_bottom_width got=%0b exp=0", at_bottom); end
      n_vec++; if (n_top !== 1 || n_bot !== 1 || n_err !== 0) begin n_miscmp++; $display("FAIL sweep_pulse_counts top=%0d bot=%0d err=%0d exp=1,1,0", n_top, n_bot, n_err); end
   endtask

   task automatic test_cycle_wrap();
      apply_reset();
      drive(4'd0);
      drive(4'd1);
      for (int s = 1; s <= 30; s++) begin
         for (int v = 2; v <= 15; v++) drive(4'(v));
         for (int v = 14; v >= 0; v--) drive(4'(v));
         drive(4'd1);
         n_vec++; if (cycles !== 4'(s % 16)) begin n_miscmp++; $display("FAIL wrap_cycles sweep=%0d got=%0d exp=%0d", s, cycles, s % 16); end
      end
      n_vec++; if (cycles !== 4'd14) begin n_miscmp++; $display("FAIL wrap_final got=%0d exp=14", cycles); end
   endtask

   task automatic test_fault_recover();
      apply_reset();
      drive(4'd3); drive(4'd4); drive(4'd5); drive(4'd6);
      n_vec++; if (state !== S_UP || step_err !== 1'b0) begin n_miscmp++; $display("FAIL fault_pre state=%0d err=%0b exp=1,0", state, step_err); end
      drive(4'd9);
      n_vec++; if (state !== S_FAULT || step_err !== 1'b1) begin n_miscmp++; $display("FAIL fault_enter state=%0d err=%0b exp=3,1", state, step_err); end
      n_vec++; if (err_count !== 4'd1 || dir !== 1'b0) begin n_miscmp++; $display("FAIL fault_cnt1 cnt=%0d dir=%0b exp=1,0", err_count, dir); end
      drive(4'd9);
      n_vec++; if (state !== S_FAULT || step_err !== 1'b0) begin n_miscmp++; $display("FAIL fault_hold state=%0d err=%0b exp=3,0", state, step_err); end
      drive(4'd3);
      n_vec++; if (step_err !== 1'b1 || err_count !== 4'd2) begin n_miscmp++; $display("FAIL fault_jump err=%0b cnt=%0d exp=1,2", step_err, err_count); end
      drive(4'd0);
      n_vec++; if (state !== S_LOCK || step_err !== 1'b0) begin n_miscmp++; $display("FAIL fault_exit state=%0d err=%0b exp=0,0", state, step_err); end
      drive(4'd1);
      n_vec++; if (state !== S_UP || err_count !== 4'd2) begin n_miscmp++; $display("FAIL fault_relock state=%0d cnt=%0d exp=1,2", state, err_count); end
   endtask

   task automatic test_wrap_faults();
      apply_reset();
      drive(4'd13); drive(4'd14); drive(4'd15);
      drive(4'd0);
      n_vec++; if (state !== S_FAULT || step_err !== 1'b1 || at_top !== 1'b0) begin n_miscmp++; $display("FAIL topwrap state=%0d err=%0b top=%0b exp=3,1,0", state, step_err, at_top); end
      apply_reset();
      drive(4'd3); drive(4'd2); drive(4'd1); drive(4'd0);
      n_vec++; if (state !== S_DOWN || dir !== 1'b1) begin n_miscmp++; $display("FAIL botwrap_pre state=%0d dir=%0b exp=2,1", state, dir); end
      drive(4'd15);
      n_vec++; if (state !== S_FAULT || step_err !== 1'b1 || at_bottom !== 1'b0) begin n_miscmp++; $display("FAIL botwrap state=%0d err=%0b bot=%0b exp=3,1,0", state, step_err, at_bottom); end
      n_vec++; if (dir !== 1'b1 || err_count !== 4'd1) begin n_miscmp++; $display("FAIL botwrap_dir dir=%0b cnt=%0d exp=1,1", dir, err_count); end
   endtask

   task automatic test_saturate_clear();
      int exp_cnt;
      apply_reset();
      drive(4'd5);
      for (int i = 0; i < 20; i++) begin
         drive((i % 2 == 0) ? 4'd9 : 4'd5);
         exp_cnt = (i + 1 > 15) ? 15 : i + 1;
         n_vec++; if (step_err !== 1'b1 || err_count !== 4'(exp_cnt)) begin n_miscmp++; $display("FAIL sat i=%0d err=%0b cnt=%0d exp=1,%0d", i, step_err, err_count, exp_cnt); end
      end
      clr_stats = 1'b1;
      drive(4'd9);
      clr_stats = 1'b0;
      n_vec++; if (err_count !== 4'd0 || step_err !== 1'b1) begin n_miscmp++; $display("FAIL clr_wins cnt=%0d err=%0b exp=0,1", err_count, step_err); end
      n_vec++; if (state !== S_LOCK) begin n_miscmp++; $display("FAIL clr_state got=%0d exp=0", state); end
      drive(4'd2);
      n_vec++; if (err_count !== 4'd1) begin n_miscmp++; $display("FAIL clr_resume got=%0d exp=1", err_count); end
   endtask

   task automatic test_reset_mid_sweep();
      apply_reset();
      drive(4'd12); drive(4'd11); drive(4'd4); drive(4'd0);
      for (int v = 15; v >= 9; v--) drive(4'(v));
      n_vec++; if (state !== S_DOWN || dir !== 1'b1 || err_count !== 4'd1 || seg !== glyph[9]) begin n_miscmp++; $display("FAIL mid_pre state=%0d dir=%0b cnt=%0d seg=%h exp=2,1,1,%h", state, dir, err_count, seg, glyph[9]); end
      #2;
      rst = 1'b1;
      #1;
      n_vec++; if (state !== S_LOCK || dir !== 1'b0 || cycles !== 4'd0 || err_count !== 4'd0) begin n_miscmp++; $display("FAIL mid_rst state=%0d dir=%0b cyc=%0d cnt=%0d exp=0,0,0,0", state, dir, cycles, err_count); end
      n_vec++; if ({step_err, at_top, at_bottom} !== 3'b000 || seg !== 7'h3F) begin n_miscmp++; $display("FAIL mid_rst_out pulses=%b seg=%h exp=000,3f", {step_err, at_top, at_bottom}, seg); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(4'd9);
      n_vec++; if ({step_err, at_top, at_bottom} !== 3'b000 || state !== S_LOCK) begin n_miscmp++; $display("FAIL mid_first pulses=%b state=%0d exp=000,0", {step_err, at_top, at_bottom}, state); end
      n_vec++; if (seg !== glyph[9]) begin n_miscmp++; $display("FAIL mid_seg9 got=%h exp=%h", seg, glyph[9]); end
      cnt_in = 4'd8;
      #3;
      n_vec++; if (seg !== glyph[9]) begin n_miscmp++; $display("FAIL mid_seg_latency got=%h exp=%h", seg, glyph[9]); end
      @(posedge clk);
      #1;
      n_vec++; if (state !== S_DOWN || dir !== 1'b1 || step_err !== 1'b0) begin n_miscmp++; $display("FAIL mid_down state=%0d dir=%0b err=%0b exp=2,1,0", state, dir, step_err); end
      n_vec++; if (seg !== glyph[8]) begin n_miscmp++; $display("FAIL mid_seg8 got=%h exp=%h", seg, glyph[8]); end
   endtask

   initial begin
      n_vec    = 0;
      n_miscmp = 0;
      test_reset();
      test_full_sweep();
      test_cycle_wrap();
      test_fault_recover();
      test_wrap_faults();
      test_saturate_clear();
      test_reset_mid_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
